// File: rtl/fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_if
//   Groups the control inputs and fetch outputs of fetch_pc_unit.
//
//   Handshake: PC is a usable fetch address only in cycles where
//   fetch_valid=1. There is no ready back-pressure. Instead, the consumer
//   holds the PC with stall=1, which leaves PC, fetch_valid and fetch_count
//   unchanged on the next edge.
//
//   Signals (driver -> unit):
//     stall, PCSrc, PCTarget[31:0], halt_req, resume
//   Signals (unit -> consumer):
//     PC[31:0], PCPlus4[31:0], fetch_valid, fault, state[1:0],
//     fetch_count[31:0]
//
//   Modports:
//     master : drives the controls and observes the outputs (core / bench)
//     slave  : the fetch PC unit itself
// ---------------------------------------------------------------------------
interface fetch_pc_if;
    logic        stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        halt_req;
    logic        resume;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        fetch_valid;
    logic        fault;
    logic [1:0]  state;
    logic [31:0] fetch_count;

    modport master (
        output stall, PCSrc, PCTarget, halt_req, resume,
        input  PC, PCPlus4, fetch_valid, fault, state, fetch_count
    );

    modport slave (
        input  stall, PCSrc, PCTarget, halt_req, resume,
        output PC, PCPlus4, fetch_valid, fault, state, fetch_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   Program-counter generator for the instruction fetch stage.
//
//   Behaviour:
//     - Starts in BOOT after reset and moves to RUN on the next edge.
//     - In RUN, it steps PC by 4 or follows a redirect. Each advance
//       increments fetch_count, which saturates at its maximum value.
//     - It can halt and later resume.
//     - An illegal redirect target parks the unit in FAULT until reset.
//
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset
//     bus : fetch_pc_if.slave
//       inputs  : stall, PCSrc, PCTarget, halt_req, resume
//       outputs : PC, PCPlus4 (combinational), fetch_valid, fault,
//                 state (BOOT=0, RUN=1, HALT=2, FAULT=3), fetch_count
//
//   Parameters:
//     RESET_VECTOR : word-aligned PC loaded on reset and used as the wrap
//                    target
//     IMEM_WORDS   : instruction memory depth in 32-bit words
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 1024
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_if.slave       bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_e;

    // One past the last legal byte address. It is held at 33 bits so that a
    // memory filling the whole 4 GiB space does not overflow the compare.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [32:0] pc_plus4_wide;
    logic        seq_wraps;
    logic        target_legal;
    logic [31:0] count_inc;

    // The carry bit is kept so that PC+4 overflowing 2^32 is still seen as
    // leaving the legal range.
    assign pc_plus4_wide = {1'b0, pc_q} + 33'd4;
    assign seq_wraps     = (pc_plus4_wide >= PC_LIMIT);
    assign target_legal  = (bus.PCTarget[1:0] == 2'b00) &&
                           ({1'b0, bus.PCTarget} < PC_LIMIT);
    assign count_inc     = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            count_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        fault_d       = fault_q;
        count_d       = count_q;

        case (state_q)
            BOOT: begin
                state_d       = RUN;
                fetch_valid_d = 1'b1;
            end
            RUN: begin
                // Priority: halt_req > stall > PCSrc > sequential.
                if (bus.halt_req) begin
                    state_d       = HALT;
                    fetch_valid_d = 1'b0;
                end else if (bus.stall) begin
                    // Hold everything.
                end else if (bus.PCSrc) begin
                    if (target_legal) begin
                        pc_d    = bus.PCTarget;
                        count_d = count_inc;
                    end else begin
                        state_d       = FAULT;
                        fault_d       = 1'b1;
                        fetch_valid_d = 1'b0;
                    end
                end else begin
                    pc_d    = seq_wraps ? RESET_VECTOR : pc_plus4_wide[31:0];
                    count_d = count_inc;
                end
            end
            HALT: begin
                fetch_valid_d = 1'b0;
                if (bus.resume) begin
                    state_d       = RUN;
                    fetch_valid_d = 1'b1;
                end
            end
            FAULT: begin
                fault_d       = 1'b1;
                fetch_valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_plus4_wide[31:0];
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fault       = fault_q;
    assign bus.state       = state_q;
    assign bus.fetch_count = count_q;

endmodule
